// File: rtl/uart_tx_fsmd_ctrl_if.sv
// Host-side word handshake for the UART transmit controller.
// The producer drives a word plus valid; the controller answers with ready.
interface uart_tx_fsmd_ctrl_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_fsmd_ctrl.sv
// UART transmit controller: FSM plus datapath that drives the serial line.
// Frames are start bit, DATA_W data bits LSB-first, optional parity, 1 or 2 stop bits.
// The baud counter paces every bit; the bit counter indexes data bits and stop bits.
module uart_tx_fsmd_ctrl #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  hard_rst,
  uart_tx_fsmd_ctrl_if.slave    host,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [BAUD_W-1:0]   baud_cnt;
  logic [BAUD_W-1:0]   baud_nxt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [BIT_W-1:0]    bit_nxt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shreg_nxt;
  logic                parity_bit;
  logic                parity_nxt;

  logic                out_nxt;
  logic                busy_nxt;
  logic                done_nxt;

  logic                baud_last;
  logic                bit_inc;
  logic                handshake;

  // Ready is a pure decode of the state so a waiting producer is taken on the idle edge.
  assign host.tx_ready = (state == S_IDLE);

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign handshake = host.tx_valid && (state == S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, counter control and next-output decode.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    parity_nxt = parity_bit;
    bit_inc    = 1'b0;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_cnt;
    out_nxt    = 1'b1;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (handshake) begin
          state_nxt  = S_START;
          shreg_nxt  = host.tx_data;
          parity_nxt = (^host.tx_data) ^ 1'(PARITY_ODD);
        end
      end

      S_START: begin
        if (baud_last) begin
          state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          shreg_nxt = {1'b0, shreg[DATA_W-1:1]};
          bit_inc   = 1'b1;
          if (bit_cnt == DATA_LAST) begin
            state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (baud_last) begin
          state_nxt = S_STOP;
        end
      end

      S_STOP: begin
        if (baud_last) begin
          bit_inc = 1'b1;
          if (bit_cnt == STOP_LAST) begin
            state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Both counters clear on any state change, so neither runs past its terminal value.
    if (state_nxt != state) begin
      baud_nxt = '0;
      bit_nxt  = '0;
    end else begin
      baud_nxt = ((state == S_IDLE) || baud_last) ? '0 : baud_cnt + BAUD_W'(1);
      bit_nxt  = bit_inc ? bit_cnt + BIT_W'(1) : bit_cnt;
    end

    // Line level is decoded from the state being entered so it changes with the state.
    case (state_nxt)
      S_IDLE:   out_nxt = 1'b1;
      S_START:  out_nxt = 1'b0;
      S_DATA:   out_nxt = shreg_nxt[0];
      S_PARITY: out_nxt = parity_nxt;
      S_STOP:   out_nxt = 1'b1;
      default:  out_nxt = 1'b1;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state == S_STOP) && (state_nxt == S_IDLE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tx_out     <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      baud_cnt   <= baud_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      parity_bit <= parity_nxt;
      tx_out     <= out_nxt;
      tx_busy    <= busy_nxt;
      tx_done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fsmd_ctrl.sv
// Bench for uart_tx_fsmd_ctrl: three differently configured instances share clock
// and reset and are compared every cycle against a frame-level reference model,
// with directed frame checks on top of randomized traffic.
module tb_uart_tx_fsmd_ctrl;

  localparam int A_DW = 8, A_CPB = 4, A_PEN = 1, A_ODD = 0, A_SB = 1;
  localparam int B_DW = 8, B_CPB = 4, B_PEN = 0, B_ODD = 0, B_SB = 2;
  localparam int C_DW = 5, C_CPB = 3, C_PEN = 1, C_ODD = 1, C_SB = 1;

  logic clk;
  logic hard_rst;

  logic [8:0] drv_data  [3];
  logic       drv_valid [3];

  logic line_a, line_b, line_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;

  uart_tx_fsmd_ctrl_if #(.DATA_W(A_DW)) if_a ();
  uart_tx_fsmd_ctrl_if #(.DATA_W(B_DW)) if_b ();
  uart_tx_fsmd_ctrl_if #(.DATA_W(C_DW)) if_c ();

  assign if_a.tx_data  = drv_data[0][A_DW-1:0];
  assign if_b.tx_data  = drv_data[1][B_DW-1:0];
  assign if_c.tx_data  = drv_data[2][C_DW-1:0];
  assign if_a.tx_valid = drv_valid[0];
  assign if_b.tx_valid = drv_valid[1];
  assign if_c.tx_valid = drv_valid[2];

  uart_tx_fsmd_ctrl #(.DATA_W(A_DW), .CLKS_PER_BIT(A_CPB), .PARITY_EN(A_PEN),
                      .PARITY_ODD(A_ODD), .STOP_BITS(A_SB)) dut_a (
    .clk(clk), .hard_rst(hard_rst), .host(if_a),
    .tx_out(line_a), .tx_busy(busy_a), .tx_done(done_a));

  uart_tx_fsmd_ctrl #(.DATA_W(B_DW), .CLKS_PER_BIT(B_CPB), .PARITY_EN(B_PEN),
                      .PARITY_ODD(B_ODD), .STOP_BITS(B_SB)) dut_b (
    .clk(clk), .hard_rst(hard_rst), .host(if_b),
    .tx_out(line_b), .tx_busy(busy_b), .tx_done(done_b));

  uart_tx_fsmd_ctrl #(.DATA_W(C_DW), .CLKS_PER_BIT(C_CPB), .PARITY_EN(C_PEN),
                      .PARITY_ODD(C_ODD), .STOP_BITS(C_SB)) dut_c (
    .clk(clk), .hard_rst(hard_rst), .host(if_c),
    .tx_out(line_c), .tx_busy(busy_c), .tx_done(done_c));

  wire [2:0] line_v = {line_c, line_b, line_a};
  wire [2:0] busy_v = {busy_c, busy_b, busy_a};
  wire [2:0] done_v = {done_c, done_b, done_a};
  wire [2:0] rdy_v  = {if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Compare one observed value with its expected value and record the outcome.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int p_dw(int k);
    return (k == 0) ? A_DW : (k == 1) ? B_DW : C_DW;
  endfunction
  function automatic int p_cpb(int k);
    return (k == 0) ? A_CPB : (k == 1) ? B_CPB : C_CPB;
  endfunction
  function automatic int p_pen(int k);
    return (k == 0) ? A_PEN : (k == 1) ? B_PEN : C_PEN;
  endfunction
  function automatic int p_odd(int k);
    return (k == 0) ? A_ODD : (k == 1) ? B_ODD : C_ODD;
  endfunction
  function automatic int p_sb(int k);
    return (k == 0) ? A_SB : (k == 1) ? B_SB : C_SB;
  endfunction

  // Frame as a list of bit slots: start, data LSB-first, optional parity, stop (rest idle-high).
  function automatic logic [15:0] frame_bits(int k, logic [8:0] w);
    logic [15:0] fb;
    logic        p;
    fb = '1;
    fb[0] = 1'b0;
    p = (p_odd(k) != 0);
    for (int i = 0; i < p_dw(k); i++) begin
      fb[4'(1 + i)] = w[4'(i)];
      p = p ^ w[4'(i)];
    end
    if (p_pen(k) != 0) fb[4'(1 + p_dw(k))] = p;
    return fb;
  endfunction

  function automatic int frame_len(int k);
    return (1 + p_dw(k) + p_pen(k) + p_sb(k)) * p_cpb(k);
  endfunction

  // Reference model state: position in the current frame measured in clk cycles.
  bit          m_busy [3];
  bit          m_done [3];
  bit          m_line [3];
  int          m_pos  [3];
  logic [15:0] m_fb   [3];

  // Reference model: advance every instance by one clock.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (hard_rst) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_line[k] <= 1'b1;
        m_pos[k]  <= 0;
      end else if (!m_busy[k]) begin
        m_done[k] <= 1'b0;
        if (drv_valid[k]) begin
          m_fb[k]   <= frame_bits(k, drv_data[k]);
          m_pos[k]  <= 0;
          m_line[k] <= 1'b0;
          m_busy[k] <= 1'b1;
        end else begin
          m_line[k] <= 1'b1;
        end
      end else if (m_pos[k] == frame_len(k) - 1) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b1;
        m_line[k] <= 1'b1;
      end else begin
        m_pos[k]  <= m_pos[k] + 1;
        m_line[k] <= m_fb[k][4'((m_pos[k] + 1) / p_cpb(k))];
      end
    end
  end

  // Advance to the next falling edge and compare every instance against the model.
  task automatic tick();
    @(negedge clk);
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("line_%0d", k), 32'(line_v[k]), 32'(m_line[k]));
        check($sformatf("busy_%0d", k), 32'(busy_v[k]), 32'(m_busy[k]));
        check($sformatf("done_%0d", k), 32'(done_v[k]), 32'(m_done[k]));
        check($sformatf("ready_%0d", k), 32'(rdy_v[k]), 32'(!m_busy[k]));
      end
    end
  endtask

  logic [10:0] pat_a = {1'b1, 1'b0, 8'hA5, 1'b0};
  int          ndone;

  initial begin
    hard_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drv_valid[k] = 1'b0;
      drv_data[k]  = '0;
    end
    repeat (3) tick();
    hard_rst = 1'b0;
    chk_on   = 1'b1;

    // Idle after reset.
    repeat (20) begin
      tick();
      check("idle_line", 32'(line_a), 32'd1);
      check("idle_ready", 32'(if_a.tx_ready), 32'd1);
      check("idle_busy", 32'(busy_a), 32'd0);
      check("idle_done", 32'(done_a), 32'd0);
    end

    // Single frames: 0xA5 on A (even parity) and B (no parity, 2 stops); 0x00 on C (odd parity).
    drv_data[0] = 9'h0A5;
    drv_data[1] = 9'h0A5;
    drv_data[2] = 9'h000;
    for (int k = 0; k < 3; k++) drv_valid[k] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) drv_valid[k] = 1'b0;
    for (int j = 1; j <= 46; j++) begin
      if (j > 1) tick();
      check($sformatf("a5_line_c%0d", j), 32'(line_a),
            (j <= 44) ? 32'(pat_a[4'((j - 1) / 4)]) : 32'd1);
      check($sformatf("a5_done_c%0d", j), 32'(done_a), 32'(j == 45));
      check($sformatf("b_done_c%0d", j), 32'(done_b), 32'(j == 45));
      check($sformatf("c_done_c%0d", j), 32'(done_c), 32'(j == 25));
      if (j >= 19 && j <= 21) check("c_odd_parity", 32'(line_c), 32'd1);
      if (j >= 37 && j <= 44) check("b_stop_high", 32'(line_b), 32'd1);
    end

    // Back-to-back on A with valid held; data changes once the first word is taken.
    drv_data[0]  = 9'h03C;
    drv_valid[0] = 1'b1;
    tick();
    drv_data[0] = 9'h0C3;
    for (int j = 1; j <= 46; j++) begin
      if (j > 1) tick();
      if (j < 45) check("b2b_ready_low", 32'(if_a.tx_ready), 32'd0);
      if (j == 45) begin
        check("b2b_gap_line", 32'(line_a), 32'd1);
        check("b2b_gap_done", 32'(done_a), 32'd1);
        check("b2b_gap_ready", 32'(if_a.tx_ready), 32'd1);
      end
      if (j == 46) begin
        check("b2b_second_start", 32'(line_a), 32'd0);
        check("b2b_second_busy", 32'(busy_a), 32'd1);
      end
    end
    drv_valid[0] = 1'b0;
    repeat (50) begin
      drv_data[0] = 9'($urandom);
      tick();
    end

    // Reset during data bit 3 of 0x5A, then a clean 0x5A frame.
    drv_data[0]  = 9'h05A;
    drv_valid[0] = 1'b1;
    tick();
    drv_valid[0] = 1'b0;
    for (int j = 2; j <= 18; j++) tick();
    hard_rst = 1'b1;
    tick();
    check("rst_line", 32'(line_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ready", 32'(if_a.tx_ready), 32'd1);
    hard_rst = 1'b0;
    ndone = 0;
    repeat (60) begin
      tick();
      if (done_a) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    drv_valid[0] = 1'b1;
    tick();
    drv_valid[0] = 1'b0;
    ndone = 0;
    repeat (50) begin
      tick();
      if (done_a) ndone++;
    end
    check("5a_one_done", 32'(ndone), 32'd1);

    // Randomized traffic with occasional resets.
    repeat (1500) begin
      for (int k = 0; k < 3; k++) begin
        drv_valid[k] = ($urandom_range(0, 3) != 0);
        drv_data[k]  = 9'($urandom);
      end
      hard_rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    hard_rst = 1'b0;
    for (int k = 0; k < 3; k++) drv_valid[k] = 1'b0;
    repeat (60) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
